// File: rtl/clock_pkg.sv
// clock_pkg: mode encoding and counter limits shared by the clock control logic.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX  = 5'd23;

endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-cycle pulse on a rising edge of a synchronous level.
// The history flop resets to 1 so a level held high through reset gives no edge.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic hist_q;
  logic hist_d;

  // History is simply the previous-cycle copy of the input.
  always_comb begin
    hist_d = din;
  end

  // History register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign rise = din & ~hist_q;

endmodule

// File: rtl/clock_ctrl_fsm.sv
// clock_ctrl_fsm: 1 Hz prescaler, RUN/SET_HR/SET_MIN mode FSM and the registered
// en_*/clr_* strobes that advance, wrap and cascade the time counters.
// Optional feature: define CLOCK_CTRL_BLINK_EN to build the 2 Hz blink divider.
module clock_ctrl_fsm
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic       en_sec,
  output logic       clr_sec,
  output logic       en_min,
  output logic       clr_min,
  output logic       en_hr,
  output logic       clr_hr,
  output logic       tick_1hz,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int               PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);

  logic          mode_rise;
  logic          inc_rise;

  mode_e         state_q,   state_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic          en_sec_q,  en_sec_d;
  logic          clr_sec_q, clr_sec_d;
  logic          en_min_q,  en_min_d;
  logic          clr_min_q, clr_min_d;
  logic          en_hr_q,   en_hr_d;
  logic          clr_hr_q,  clr_hr_d;
  logic          tick_q,    tick_d;

  edge_detect u_mode_edge (
    .clk  (clk),
    .reset(reset),
    .din  (btn_mode),
    .rise (mode_rise)
  );

  edge_detect u_inc_edge (
    .clk  (clk),
    .reset(reset),
    .din  (btn_inc),
    .rise (inc_rise)
  );

  // Next state, prescaler and strobe decode; a mode edge always beats an increment edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    presc_d   = presc_q;
    en_sec_d  = 1'b0;
    clr_sec_d = 1'b0;
    en_min_d  = 1'b0;
    clr_min_d = 1'b0;
    en_hr_d   = 1'b0;
    clr_hr_d  = 1'b0;
    tick_d    = 1'b0;

    case (state_q)
      MODE_RUN: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (sec != SEC_MAX) begin
            en_sec_d = 1'b1;
          end else begin
            clr_sec_d = 1'b1;
            if (min != MIN_MAX) begin
              en_min_d = 1'b1;
            end else begin
              clr_min_d = 1'b1;
              if (hour != HR_MAX) en_hr_d  = 1'b1;
              else                clr_hr_d = 1'b1;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
        // Increment edges are ignored while the clock is running.
        if (mode_rise) begin
          state_d = MODE_SET_HR;
          presc_d = '0;
        end
      end

      MODE_SET_HR: begin
        presc_d = '0;
        if (mode_rise) begin
          state_d = MODE_SET_MIN;
        end else if (inc_rise) begin
          if (hour != HR_MAX) en_hr_d  = 1'b1;
          else                clr_hr_d = 1'b1;
        end
      end

      MODE_SET_MIN: begin
        presc_d = '0;
        if (mode_rise) begin
          // Restart the second from zero so the first RUN tick is a full period away.
          state_d   = MODE_RUN;
          clr_sec_d = 1'b1;
        end else if (inc_rise) begin
          // Minutes wrap on their own; setting never carries into hours.
          if (min != MIN_MAX) en_min_d  = 1'b1;
          else                clr_min_d = 1'b1;
        end
      end

      default: begin
        state_d = MODE_RUN;
        presc_d = '0;
      end
    endcase
  end

  // State, prescaler and registered strobes; reset overrides any pending strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= MODE_RUN;
      presc_q   <= '0;
      en_sec_q  <= 1'b0;
      clr_sec_q <= 1'b0;
      en_min_q  <= 1'b0;
      clr_min_q <= 1'b0;
      en_hr_q   <= 1'b0;
      clr_hr_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      en_sec_q  <= en_sec_d;
      clr_sec_q <= clr_sec_d;
      en_min_q  <= en_min_d;
      clr_min_q <= clr_min_d;
      en_hr_q   <= en_hr_d;
      clr_hr_q  <= clr_hr_d;
      tick_q    <= tick_d;
    end
  end

  assign en_sec   = en_sec_q;
  assign clr_sec  = clr_sec_q;
  assign en_min   = en_min_q;
  assign clr_min  = clr_min_q;
  assign en_hr    = en_hr_q;
  assign clr_hr   = clr_hr_q;
  assign tick_1hz = tick_q;
  assign mode     = state_q;

`ifdef CLOCK_CTRL_BLINK_EN
  localparam int            BLINK_DIV  = TICK_DIV / 4;
  localparam int            BW         = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_q,  bcnt_d;
  logic          blink_q, blink_d;

  // Half-period divider for the blink square wave; held cleared whenever RUN is next.
  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (state_d == MODE_RUN) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
    end else if (bcnt_q == BLINK_LAST) begin
      bcnt_d  = '0;
      blink_d = ~blink_q;
    end else begin
      bcnt_d = bcnt_q + BW'(1);
    end
  end

  // Blink divider registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

endmodule
